// File: rtl/cache_miss_ctrl_pkg.sv
// cache_pkg: shared constants and helpers for the M-stage cache miss controller.
//   NUM_WAYS  - associativity of the tag store (fixed at 4)
//   PLRU_W    - tree pseudo-LRU bits per set (3 for a 4-way tree)
//   ST_*      - controller state encodings
//   way_t     - one-hot way vector
//   lowest_onehot / more_than_one / onehot_to_idx - one-hot helpers
package cache_pkg;

    localparam int NUM_WAYS = 4;
    localparam int PLRU_W   = 3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_MISS_REQ  = 3'd2;
    localparam logic [2:0] ST_MISS_WAIT = 3'd3;
    localparam logic [2:0] ST_FILL      = 3'd4;
    localparam logic [2:0] ST_RESP      = 3'd5;

    typedef logic [NUM_WAYS-1:0] way_t;

    // Isolates the lowest set bit (two's-complement trick); zero in, zero out.
    function automatic way_t lowest_onehot(way_t v);
        return v & (~v + 4'd1);
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something.
    function automatic logic more_than_one(way_t v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    // One-hot to binary way number; a zero vector maps to way 0.
    function automatic logic [1:0] onehot_to_idx(way_t v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// cache_miss_ctrl_if: all non-clock signals of the miss controller.
//   request side : req_valid/req_ready/req_index/req_tag
//   tag store    : ts_valid/ts_r/ts_w/ts_index/ts_way/ts_tag, hit back
//   memory       : mem_req_valid/mem_req_ready/mem_req_addr, mem_resp_valid
//   completion   : done/done_hit/done_way, multi_hit error pulse
// Modport master is the controller; slave is its environment.
interface cache_miss_ctrl_if #(
    parameter int TAG_W = 8,
    parameter int IDX_W = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic [IDX_W-1:0]       req_index;
    logic [TAG_W-1:0]       req_tag;

    logic                   ts_valid;
    logic                   ts_r;
    logic                   ts_w;
    logic [IDX_W-1:0]       ts_index;
    logic [3:0]             ts_way;
    logic [TAG_W-1:0]       ts_tag;
    logic [3:0]             hit;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [TAG_W+IDX_W-1:0] mem_req_addr;
    logic                   mem_resp_valid;

    logic                   done;
    logic                   done_hit;
    logic [3:0]             done_way;
    logic                   multi_hit;

    modport master (
        input  req_valid, req_index, req_tag, hit, mem_req_ready, mem_resp_valid,
        output req_ready, ts_valid, ts_r, ts_w, ts_index, ts_way, ts_tag,
               mem_req_valid, mem_req_addr, done, done_hit, done_way, multi_hit
    );

    modport slave (
        output req_valid, req_index, req_tag, hit, mem_req_ready, mem_resp_valid,
        input  req_ready, ts_valid, ts_r, ts_w, ts_index, ts_way, ts_tag,
               mem_req_valid, mem_req_addr, done, done_hit, done_way, multi_hit
    );
endinterface

// File: rtl/cache_miss_ctrl_plru_tree4.sv
// plru_tree4: combinational 4-way tree pseudo-LRU.
//   plru_bits  in  3  b0 picks the pair (0: ways 0/1, 1: ways 2/3),
//                     b1 picks within 0/1, b2 picks within 2/3
//   access_way in  4  one-hot way being touched
//   victim     out 4  one-hot way the tree currently points at
//   plru_next  out 3  tree bits after touching access_way
module plru_tree4
    import cache_pkg::*;
(
    input  logic [PLRU_W-1:0] plru_bits,
    input  way_t              access_way,
    output way_t              victim,
    output logic [PLRU_W-1:0] plru_next
);

    always_comb begin
        if (!plru_bits[0]) begin
            victim = plru_bits[1] ? 4'b0010 : 4'b0001;
        end else begin
            victim = plru_bits[2] ? 4'b1000 : 4'b0100;
        end

        // Touching a way points every bit on its path at the other half.
        plru_next = plru_bits;
        case (onehot_to_idx(access_way))
            2'd0: begin
                plru_next[0] = 1'b1;
                plru_next[1] = 1'b1;
            end
            2'd1: begin
                plru_next[0] = 1'b1;
                plru_next[1] = 1'b0;
            end
            2'd2: begin
                plru_next[0] = 1'b0;
                plru_next[2] = 1'b1;
            end
            default: begin
                plru_next[0] = 1'b0;
                plru_next[2] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: lookup/miss controller in front of a 4-way tag store.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any transaction, clears valid/PLRU)
//   bus  - cache_miss_ctrl_if.master: request, tag store, memory and completion signals
// One request at a time: LOOKUP reads the tag store; a hit finishes via RESP,
// a miss picks a victim (first invalid way, else PLRU), fetches the line,
// writes the tag in FILL and finishes via RESP.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int TAG_W = 8,
    parameter int IDX_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    cache_miss_ctrl_if.master bus
);

    localparam int NUM_SETS = 2 ** IDX_W;

    logic [2:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [TAG_W-1:0] tag_reg;
    way_t             victim_reg;
    way_t             way_reg;
    logic             hit_flag_reg;

    logic [NUM_SETS*NUM_WAYS-1:0] valid_flat;
    logic [NUM_SETS*PLRU_W-1:0]   plru_flat;

    way_t              cur_valid;
    logic [PLRU_W-1:0] cur_plru;
    logic [PLRU_W-1:0] plru_next;
    way_t              plru_victim;
    way_t              hit_way;
    way_t              victim_sel;
    way_t              access_way;
    logic              hit_any;
    logic              plru_we;
    logic              valid_we;

    // Per-set valid and PLRU state; only the latched set is ever updated.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
            logic [NUM_WAYS-1:0] valid_reg;
            logic [PLRU_W-1:0]   plru_reg;
            logic                set_sel;

            assign set_sel = (idx_reg == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= '0;
                    plru_reg  <= '0;
                end else if (set_sel) begin
                    if (valid_we) begin
                        valid_reg <= valid_reg | victim_reg;
                    end
                    if (plru_we) begin
                        plru_reg <= plru_next;
                    end
                end
            end

            assign valid_flat[gi*NUM_WAYS +: NUM_WAYS] = valid_reg;
            assign plru_flat[gi*PLRU_W +: PLRU_W]      = plru_reg;
        end
    endgenerate

    plru_tree4 u_plru (
        .plru_bits  (cur_plru),
        .access_way (access_way),
        .victim     (plru_victim),
        .plru_next  (plru_next)
    );

    always_comb begin
        cur_valid  = valid_flat[idx_reg*NUM_WAYS +: NUM_WAYS];
        cur_plru   = plru_flat[idx_reg*PLRU_W +: PLRU_W];
        hit_any    = (bus.hit != 4'd0);
        hit_way    = lowest_onehot(bus.hit);
        // An empty way always beats the PLRU choice.
        victim_sel = (&cur_valid) ? plru_victim : lowest_onehot(~cur_valid);
        // The tree is touched by the hit way in LOOKUP or the victim in FILL.
        access_way = (state_reg == ST_FILL) ? victim_reg : hit_way;
        plru_we    = ((state_reg == ST_LOOKUP) && hit_any) || (state_reg == ST_FILL);
        valid_we   = (state_reg == ST_FILL);
    end

    // Next-state and output decode; everything is a function of state so the
    // tag store sees stable index/tag for the whole LOOKUP cycle.
    always_comb begin
        state_next        = state_reg;
        bus.req_ready     = 1'b0;
        bus.ts_valid      = 1'b0;
        bus.ts_r          = 1'b0;
        bus.ts_w          = 1'b0;
        bus.ts_index      = '0;
        bus.ts_way        = '0;
        bus.ts_tag        = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.done          = 1'b0;
        bus.done_hit      = 1'b0;
        bus.done_way      = '0;
        bus.multi_hit     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                bus.ts_valid  = 1'b1;
                bus.ts_r      = 1'b1;
                bus.ts_index  = idx_reg;
                bus.ts_tag    = tag_reg;
                bus.multi_hit = more_than_one(bus.hit);
                state_next    = hit_any ? ST_RESP : ST_MISS_REQ;
            end
            ST_MISS_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {tag_reg, idx_reg};
                if (bus.mem_req_ready) begin
                    state_next = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                bus.ts_valid = 1'b1;
                bus.ts_w     = 1'b1;
                bus.ts_way   = victim_reg;
                bus.ts_index = idx_reg;
                bus.ts_tag   = tag_reg;
                state_next   = ST_RESP;
            end
            ST_RESP: begin
                bus.done     = 1'b1;
                bus.done_hit = hit_flag_reg;
                bus.done_way = way_reg;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            tag_reg      <= '0;
            victim_reg   <= '0;
            way_reg      <= '0;
            hit_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        idx_reg <= bus.req_index;
                        tag_reg <= bus.req_tag;
                    end
                end
                ST_LOOKUP: begin
                    hit_flag_reg <= hit_any;
                    if (hit_any) begin
                        way_reg <= hit_way;
                    end else begin
                        victim_reg <= victim_sel;
                        way_reg    <= victim_sel;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: self-checking bench for cache_miss_ctrl.
// A small tag-store model answers lookups and absorbs fills; a separate
// reference model (tags, valid flags, PLRU tree in plain arithmetic) predicts
// hit/way for each request. Directed table, hand sequences, then random traffic.
module tb_cache_miss_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_miss_ctrl_if #(.TAG_W(8), .IDX_W(2)) bus ();

    cache_miss_ctrl #(.TAG_W(8), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // ---------------- tag store model ----------------
    logic [7:0] st_tag [4][4];
    bit         st_v   [4][4];
    logic [3:0] store_hit;
    bit         force_hit_en = 1'b0;
    logic [3:0] force_hit    = 4'd0;

    always_comb begin
        store_hit = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (st_v[bus.ts_index][i] && st_tag[bus.ts_index][i] == bus.ts_tag) begin
                store_hit[i] = 1'b1;
            end
        end
        bus.hit = 4'd0;
        if (bus.ts_valid && bus.ts_r) begin
            bus.hit = force_hit_en ? force_hit : store_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                for (int i = 0; i < 4; i++) begin
                    st_v[s][i] <= 1'b0;
                end
            end
        end else if (bus.ts_valid && bus.ts_w) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ts_way[i]) begin
                    st_v[bus.ts_index][i]   <= 1'b1;
                    st_tag[bus.ts_index][i] <= bus.ts_tag;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_tag [4][4];
    bit         ref_v   [4][4];
    bit         pb0 [4];
    bit         pb1 [4];
    bit         pb2 [4];

    task automatic ref_clear();
        for (int s = 0; s < 4; s++) begin
            pb0[s] = 0; pb1[s] = 0; pb2[s] = 0;
            for (int i = 0; i < 4; i++) ref_v[s][i] = 0;
        end
    endtask

    task automatic ref_access(input int s, input logic [7:0] t, output bit h, output int w);
        h = 0;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            if (w < 0 && ref_v[s][i] && ref_tag[s][i] == t) begin
                h = 1;
                w = i;
            end
        end
        if (!h) begin
            for (int i = 0; i < 4; i++) begin
                if (w < 0 && !ref_v[s][i]) w = i;
            end
            if (w < 0) w = pb0[s] ? 2 + int'(pb2[s]) : int'(pb1[s]);
            ref_v[s][w]   = 1;
            ref_tag[s][w] = t;
        end
        // point the tree away from the touched way
        if (w < 2) begin
            pb0[s] = 1;
            pb1[s] = (w == 0);
        end else begin
            pb0[s] = 0;
            pb2[s] = (w == 2);
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input string what, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, what, act, exp);
        end
    endtask

    typedef struct {
        bit         done;
        bit         done_hit;
        logic [3:0] done_way;
        int         lat;
        int         nreq;
        logic [9:0] addr;
        bit         addr_unstable;
        int         nw;
        logic [3:0] ts_way;
        logic [7:0] ts_tag;
        logic [1:0] ts_idx;
        int         nmulti;
        int         resp_cyc;
        int         fill_cyc;
    } obs_t;

    // Issue one request from IDLE, act as memory with the given delays,
    // record everything the controller does until done (bounded).
    task automatic run_txn(input string nm, input logic [1:0] idx, input logic [7:0] tag,
                           input int rdy_dly, input int rsp_dly, output obs_t o);
        int  rdy_cnt;
        int  rsp_cnt;
        bit  accepted;
        o = '{default: 0};
        rdy_cnt  = 0;
        rsp_cnt  = 0;
        accepted = 0;
        chk(nm, "req_ready", longint'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        bus.req_tag   = tag;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc < 80 && !o.done; cyc++) begin
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid) begin
                bus.mem_req_ready = (rdy_cnt >= rdy_dly);
                rdy_cnt++;
            end
            bus.mem_resp_valid = accepted && (rsp_cnt == rsp_dly);
            if (bus.mem_resp_valid) o.resp_cyc = cyc;
            if (accepted) rsp_cnt++;
            #1;
            if (bus.mem_req_valid) begin
                if (o.nreq == 0) o.addr = bus.mem_req_addr;
                else if (bus.mem_req_addr != o.addr) o.addr_unstable = 1;
                o.nreq++;
                if (bus.mem_req_ready) accepted = 1;
            end
            if (bus.ts_w) begin
                o.nw++;
                o.ts_way   = bus.ts_way;
                o.ts_tag   = bus.ts_tag;
                o.ts_idx   = bus.ts_index;
                o.fill_cyc = cyc;
            end
            if (bus.multi_hit) o.nmulti++;
            if (bus.done) begin
                o.done     = 1;
                o.lat      = cyc;
                o.done_hit = bus.done_hit;
                o.done_way = bus.done_way;
            end
            @(posedge clk); #1;
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        $display("txn %s idx=%0d tag=%02h rdy=%0d rsp=%0d -> done=%0d hit=%0d way=%b lat=%0d",
                 nm, idx, tag, rdy_dly, rsp_dly, o.done, o.done_hit, o.done_way, o.lat);
    endtask

    task automatic check_obs(input string nm, input obs_t o, input logic [1:0] idx,
                             input logic [7:0] tag, input bit eh, input logic [3:0] ew,
                             input int rdy, input int exp_lat);
        chk(nm, "done", longint'(o.done), 1);
        chk(nm, "done_hit", longint'(o.done_hit), longint'(eh));
        chk(nm, "done_way", longint'(o.done_way), longint'(ew));
        chk(nm, "latency", o.lat, exp_lat);
        chk(nm, "multi_hit", o.nmulti, 0);
        if (eh) begin
            chk(nm, "mem_req_cycles", o.nreq, 0);
            chk(nm, "fills", o.nw, 0);
        end else begin
            chk(nm, "mem_req_cycles", o.nreq, rdy + 1);
            chk(nm, "mem_req_addr", longint'(o.addr), longint'({tag, idx}));
            chk(nm, "addr_unstable", longint'(o.addr_unstable), 0);
            chk(nm, "fills", o.nw, 1);
            chk(nm, "ts_way", longint'(o.ts_way), longint'(ew));
            chk(nm, "ts_tag", longint'(o.ts_tag), longint'(tag));
            chk(nm, "ts_index", longint'(o.ts_idx), longint'(idx));
            chk(nm, "fill_after_resp", o.fill_cyc, o.resp_cyc + 1);
        end
    endtask

    function automatic logic [35:0] out_bundle();
        return {bus.req_ready, bus.ts_valid, bus.ts_r, bus.ts_w, bus.ts_index, bus.ts_way,
                bus.ts_tag, bus.mem_req_valid, bus.mem_req_addr, bus.done, bus.done_hit,
                bus.done_way, bus.multi_hit};
    endfunction

    typedef struct {
        logic [1:0] idx;
        logic [7:0] tag;
        int         rdy;
        int         rsp;
        bit         exp_hit;
        logic [3:0] exp_way;
        int         exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        obs_t       o;
        bit         eh;
        int         w;
        logic [1:0] ridx;
        logic [7:0] rtag;
        int         rrdy;
        int         rrsp;
        int         bad_w;
        int         bad_done;

        vecs[0] = '{2'd0, 8'hA1, 0, 0, 1'b0, 4'b0001, 5};
        vecs[1] = '{2'd1, 8'hB0, 0, 0, 1'b0, 4'b0001, 5};
        vecs[2] = '{2'd1, 8'hB1, 0, 0, 1'b0, 4'b0010, 5};
        vecs[3] = '{2'd1, 8'hB2, 0, 0, 1'b0, 4'b0100, 5};
        vecs[4] = '{2'd1, 8'hB3, 0, 0, 1'b0, 4'b1000, 5};
        vecs[5] = '{2'd1, 8'hB0, 0, 0, 1'b1, 4'b0001, 2};
        vecs[6] = '{2'd1, 8'hC5, 0, 0, 1'b0, 4'b0100, 5};   // PLRU after 0,1,2,3,0
        vecs[7] = '{2'd1, 8'hB2, 5, 3, 1'b0, 4'b0010, 13};  // slow memory
        vecs[8] = '{2'd1, 8'hC5, 0, 0, 1'b1, 4'b0100, 2};
        vecs[9] = '{2'd2, 8'h3C, 2, 1, 1'b0, 4'b0001, 8};

        bus.req_valid      = 1'b0;
        bus.req_index      = '0;
        bus.req_tag        = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        ref_clear();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset", "outputs", longint'(out_bundle()), longint'({1'b1, 35'd0}));

        // directed table
        for (int v = 0; v < 10; v++) begin
            ref_access(int'(vecs[v].idx), vecs[v].tag, eh, w);
            run_txn($sformatf("vec%0d", v), vecs[v].idx, vecs[v].tag, vecs[v].rdy, vecs[v].rsp, o);
            check_obs($sformatf("vec%0d", v), o, vecs[v].idx, vecs[v].tag, vecs[v].exp_hit,
                      vecs[v].exp_way, vecs[v].rdy, vecs[v].exp_lat);
        end

        // multiple hit bits: lowest wins, error pulse once
        force_hit_en = 1'b1;
        force_hit    = 4'b0101;
        run_txn("multi", 2'd3, 8'h77, 0, 0, o);
        force_hit_en = 1'b0;
        chk("multi", "done", longint'(o.done), 1);
        chk("multi", "done_hit", longint'(o.done_hit), 1);
        chk("multi", "done_way", longint'(o.done_way), 4'b0001);
        chk("multi", "latency", o.lat, 2);
        chk("multi", "multi_hit", o.nmulti, 1);
        chk("multi", "mem_req_cycles", o.nreq, 0);

        // reset while waiting for the line, then a late response
        bad_w    = 0;
        bad_done = 0;
        bus.req_valid = 1'b1;
        bus.req_index = 2'd1;
        bus.req_tag   = 8'hEE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_miss", "mem_req_valid", longint'(bus.mem_req_valid), 1);
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        if (bus.ts_w) bad_w++;
        if (bus.done) bad_done++;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.ts_w) bad_w++;
            if (bus.done) bad_done++;
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
        end
        $display("txn rst_miss idx=1 tag=ee -> fills=%0d dones=%0d req_ready=%0d",
                 bad_w, bad_done, bus.req_ready);
        chk("rst_miss", "fills", bad_w, 0);
        chk("rst_miss", "dones", bad_done, 0);
        chk("rst_miss", "req_ready", longint'(bus.req_ready), 1);
        chk("rst_miss", "outputs", longint'(out_bundle()), longint'({1'b1, 35'd0}));
        ref_clear();
        ref_access(1, 8'h11, eh, w);
        run_txn("post_rst", 2'd1, 8'h11, 0, 0, o);
        check_obs("post_rst", o, 2'd1, 8'h11, 1'b0, 4'b0001, 0, 5);

        // random traffic against the reference model
        for (int n = 0; n < 48; n++) begin
            ridx = 2'($urandom_range(0, 3));
            rtag = 8'h40 + 8'($urandom_range(0, 5));
            rrdy = int'($urandom_range(0, 3));
            rrsp = int'($urandom_range(0, 3));
            ref_access(int'(ridx), rtag, eh, w);
            run_txn($sformatf("rand%0d", n), ridx, rtag, rrdy, rrsp, o);
            check_obs($sformatf("rand%0d", n), o, ridx, rtag, eh, 4'(1 << w), rrdy,
                      eh ? 2 : 5 + rrdy + rrsp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
